// File: rtl/shift_register_sequencer_pkg.sv
// Shared encodings for the counted-shift sequencer: shift modes, direction and FSM states.
package shift_register_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_LOGIC = 2'b00,
        MODE_ROT   = 2'b01,
        MODE_ARITH = 2'b10,
        MODE_RSVD  = 2'b11
    } shiftMode_t;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } shiftDir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } seqState_t;

endpackage

// File: rtl/shift_register_sequencer_step.sv
// Combinational single-step shifter: next register value and the bit shifted out.
module shift_step_unit
    import shift_register_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d,
    input  shiftDir_t        dir,
    input  shiftMode_t       mode,
    input  logic             ShiftInput,
    output logic [WIDTH-1:0] nextD,
    output logic             outBit
);

    logic fillBit;

    always_comb begin
        fillBit = ShiftInput;
        nextD   = d;
        outBit  = 1'b0;
        if (dir == DIR_RIGHT) begin
            // Reserved mode falls through to logical fill.
            case (mode)
                MODE_ROT:   fillBit = d[0];
                MODE_ARITH: fillBit = d[WIDTH-1];
                default:    fillBit = ShiftInput;
            endcase
            nextD  = {fillBit, d[WIDTH-1:1]};
            outBit = d[0];
        end else begin
            case (mode)
                MODE_ROT:   fillBit = d[WIDTH-1];
                MODE_ARITH: fillBit = 1'b0;
                default:    fillBit = ShiftInput;
            endcase
            nextD  = {d[WIDTH-2:0], fillBit};
            outBit = d[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_register_sequencer.sv
// Universal shift register with a counted-shift sequencer and Busy/Done handshake.
module shift_register_sequencer
    import shift_register_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clockPulse,
    input  logic             Reset,
    input  logic             ParallelLoad,
    input  logic [WIDTH-1:0] Data,
    input  logic             Start,
    input  logic             Dir,
    input  logic [1:0]       Mode,
    input  logic [CNT_W-1:0] Count,
    input  logic             ShiftInput,
    output logic [WIDTH-1:0] dataBus,
    output logic             ShiftOutput,
    output logic             Busy,
    output logic             Done
);

    seqState_t        state;
    shiftDir_t        cmdDir;
    shiftMode_t       cmdMode;
    logic [CNT_W-1:0] stepCnt;
    logic [WIDTH-1:0] nextD;
    logic             outBit;

    shift_step_unit #(.WIDTH(WIDTH)) stepUnit (
        .d          (dataBus),
        .dir        (cmdDir),
        .mode       (cmdMode),
        .ShiftInput (ShiftInput),
        .nextD      (nextD),
        .outBit     (outBit)
    );

    always_ff @(posedge clockPulse) begin
        if (Reset) begin
            dataBus     <= '0;
            ShiftOutput <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            state       <= IDLE;
            stepCnt     <= '0;
            cmdDir      <= DIR_RIGHT;
            cmdMode     <= MODE_LOGIC;
        end else if (ParallelLoad) begin
            dataBus <= Data;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            state   <= IDLE;
        end else begin
            case (state)
                SHIFT: begin
                    dataBus     <= nextD;
                    ShiftOutput <= outBit;
                    stepCnt     <= stepCnt - 1'b1;
                    if (stepCnt == CNT_W'(1)) begin
                        state <= DONE;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new command, giving back-to-back issue.
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                    if (Start) begin
                        cmdDir  <= shiftDir_t'(Dir);
                        cmdMode <= shiftMode_t'(Mode);
                        stepCnt <= Count;
                        if (Count != '0) begin
                            state <= SHIFT;
                            Busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            Done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
